mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_pkg.sv | 49 ++++
 rtl/mem_if.sv | 20 ++
 rtl/mem_load_align.sv | 33 +++
 rtl/mem_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: funct3 load/store codes, FSM states,
// byte-enable constants and access-size helpers.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Loads and stores share the size encoding; anything unrecognised is a word.
  function automatic acc_size_e access_size(input logic [2:0] f3);
    case (f3)
      F3_SB, F3_LBU: return SZ_BYTE;
      F3_SH, F3_LHU: return SZ_HALF;
      F3_SW:         return SZ_WORD;
      default:       return SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (access_size(f3))
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword of a read word and sign/zero-extends it.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LHU:  result = {16'h0, half_sel};
      F3_LW:   result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: passes ALU results through, runs loads/stores on the dmem bus
// with a wait-for-ready timeout. Define MEM_MISALIGN_CHECK_EN to reject misaligned accesses.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        execute_enable_out,
  input  logic [31:0] EX_MEM_ALUResult,
  input  logic [31:0] EX_MEM_WriteData,
  input  logic [4:0]  EX_MEM_Rd,
  input  logic        EX_MEM_RegWrite,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic [2:0]  EX_MEM_Funct3,
  mem_if.master       dmem,
  output logic [31:0] MEM_WB_ReadData,
  output logic [31:0] MEM_WB_ALUResult,
  output logic [4:0]  MEM_WB_Rd,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_MemToReg,
  output logic        memory_enable_out,
  output logic        mem_stall,
  output logic        mem_error
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  mem_state_e  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic        load_q, load_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic        wb_memtoreg_q, wb_memtoreg_d;
  logic        en_q, en_d;
  logic        err_q, err_d;

  logic        is_mem, is_load, misalign, start;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] load_data;

  mem_load_align u_align (
    .rdata   (dmem.dmem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .result  (load_data)
  );

  // Entry decode: store lane steering and the misalignment guard.
  always_comb begin
    is_mem  = EX_MEM_MemRead | EX_MEM_MemWrite;
    is_load = EX_MEM_MemRead & ~EX_MEM_MemWrite;
`ifdef MEM_MISALIGN_CHECK_EN
    misalign = is_mem & misaligned(EX_MEM_Funct3, EX_MEM_ALUResult[1:0]);
`else
    misalign = 1'b0;
`endif
    st_be    = BE_WORD;
    st_wdata = EX_MEM_WriteData;
    case (access_size(EX_MEM_Funct3))
      SZ_BYTE: begin
        st_be    = BE_BYTE << EX_MEM_ALUResult[1:0];
        st_wdata = {4{EX_MEM_WriteData[7:0]}};
      end
      SZ_HALF: begin
        st_be    = BE_HALF << {EX_MEM_ALUResult[1], 1'b0};
        st_wdata = {2{EX_MEM_WriteData[15:0]}};
      end
      default: ;
    endcase
    start = (state_q == ST_IDLE) & execute_enable_out & is_mem & ~misalign;
  end

  assign mem_stall = start | (state_q == ST_ACCESS);

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    f3_d          = f3_q;
    rd_d          = rd_q;
    regwrite_d    = regwrite_q;
    load_d        = load_q;
    wb_rdata_d    = wb_rdata_q;
    wb_alu_d      = wb_alu_q;
    wb_rd_d       = wb_rd_q;
    wb_regwrite_d = wb_regwrite_q;
    wb_memtoreg_d = wb_memtoreg_q;
    en_d          = en_q;
    err_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!execute_enable_out) begin
          en_d          = 1'b0;
          wb_regwrite_d = 1'b0;
        end else if (!is_mem) begin
          wb_rdata_d    = '0;
          wb_alu_d      = EX_MEM_ALUResult;
          wb_rd_d       = EX_MEM_Rd;
          wb_regwrite_d = EX_MEM_RegWrite;
          wb_memtoreg_d = 1'b0;
          en_d          = 1'b1;
        end else if (misalign) begin
          err_d         = 1'b1;
          wb_regwrite_d = 1'b0;
          en_d          = 1'b0;
        end else begin
          addr_d        = EX_MEM_ALUResult;
          wdata_d       = EX_MEM_MemWrite ? st_wdata : '0;
          be_d          = EX_MEM_MemWrite ? st_be : BE_WORD;
          f3_d          = EX_MEM_Funct3;
          rd_d          = EX_MEM_Rd;
          regwrite_d    = EX_MEM_RegWrite;
          load_d        = is_load;
          we_d          = EX_MEM_MemWrite;
          req_d         = 1'b1;
          wait_cnt_d    = '0;
          wb_regwrite_d = 1'b0;
          en_d          = 1'b0;
          state_d       = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // Ready wins over timeout when both land on the last permitted cycle.
        if (dmem.dmem_ready) begin
          req_d         = 1'b0;
          we_d          = 1'b0;
          wb_rdata_d    = load_q ? load_data : '0;
          wb_alu_d      = addr_q;
          wb_rd_d       = rd_q;
          wb_regwrite_d = regwrite_q & load_q;
          wb_memtoreg_d = load_q;
          en_d          = 1'b1;
          state_d       = ST_IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          req_d         = 1'b0;
          we_d          = 1'b0;
          err_d         = 1'b1;
          wb_regwrite_d = 1'b0;
          en_d          = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= BE_NONE;
      f3_q          <= '0;
      rd_q          <= '0;
      regwrite_q    <= 1'b0;
      load_q        <= 1'b0;
      wb_rdata_q    <= '0;
      wb_alu_q      <= '0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      en_q          <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      f3_q          <= f3_d;
      rd_q          <= rd_d;
      regwrite_q    <= regwrite_d;
      load_q        <= load_d;
      wb_rdata_q    <= wb_rdata_d;
      wb_alu_q      <= wb_alu_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      en_q          <= en_d;
      err_q         <= err_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

  assign MEM_WB_ReadData   = wb_rdata_q;
  assign MEM_WB_ALUResult  = wb_alu_q;
  assign MEM_WB_Rd         = wb_rd_q;
  assign MEM_WB_RegWrite   = wb_regwrite_q;
  assign MEM_WB_MemToReg   = wb_memtoreg_q;
  assign memory_enable_out = en_q;
  assign mem_error         = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// transactions checked against a byte-lane arithmetic reference model.
module tb_mem_stage;

  localparam int unsigned WAIT_LIMIT = 15;
`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_alu, ex_wd;
  logic [4:0]  ex_rd;
  logic        ex_rw, ex_mr, ex_mw;
  logic [2:0]  ex_f3;
  logic [31:0] wb_rdata, wb_alu;
  logic [4:0]  wb_rd;
  logic        wb_rw, wb_m2r, mem_en, stall, err;

  int checks = 0;
  int errors = 0;

  logic        obs_we;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  int unsigned obs_stall;

  mem_if bus();

  mem_stage #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk                (clk),
    .reset              (reset),
    .execute_enable_out (ex_valid),
    .EX_MEM_ALUResult   (ex_alu),
    .EX_MEM_WriteData   (ex_wd),
    .EX_MEM_Rd          (ex_rd),
    .EX_MEM_RegWrite    (ex_rw),
    .EX_MEM_MemRead     (ex_mr),
    .EX_MEM_MemWrite    (ex_mw),
    .EX_MEM_Funct3      (ex_f3),
    .dmem               (bus),
    .MEM_WB_ReadData    (wb_rdata),
    .MEM_WB_ALUResult   (wb_alu),
    .MEM_WB_Rd          (wb_rd),
    .MEM_WB_RegWrite    (wb_rw),
    .MEM_WB_MemToReg    (wb_m2r),
    .memory_enable_out  (mem_en),
    .mem_stall          (stall),
    .mem_error          (err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int unsigned sz_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdw, input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    case (sz_of(f3))
      1: begin
        v = (rdw >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2: begin
        v = (rdw >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = rdw;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [2:0] f3, input logic load);
    if (load) return 4'hF;
    case (sz_of(f3))
      1:       return 4'(1 << (a % 4));
      2:       return 4'(3 << (2 * ((a / 2) % 2)));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [2:0] f3);
    case (sz_of(f3))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    ex_valid = 1'b0; ex_alu = '0; ex_wd = '0; ex_rd = '0;
    ex_rw = 1'b0; ex_mr = 1'b0; ex_mw = 1'b0; ex_f3 = '0;
  endtask

  // One complete EX/MEM entry; ready arrives in ACCESS cycle d+1.
  task automatic do_txn(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd, input logic rw, input logic [2:0] f3,
                        input int unsigned d, input logic [31:0] rdw);
    logic is_mem, load, mis;
    logic [31:0] exp_rdata, exp_wdata;
    logic [3:0]  exp_be;
    is_mem    = mr | mw;
    load      = mr & ~mw;
    mis       = MIS_EN && is_mem && ((a % sz_of(f3)) != 0);
    exp_be    = ref_be(a, f3, load);
    exp_wdata = ref_wdata(wd, f3);
    exp_rdata = load ? ref_load(rdw, a, f3) : 32'h0;
    obs_stall = 0;

    ex_valid = 1'b1; ex_alu = a; ex_wd = wd; ex_rd = rd;
    ex_rw = rw; ex_mr = mr; ex_mw = mw; ex_f3 = f3;
    #1;
    checks++; if (stall !== (is_mem && !mis)) begin errors++; $display("FAIL stall_entry got %b exp %b", stall, is_mem && !mis); end
    if (stall === 1'b1) obs_stall++;
    step;

    if (!is_mem) begin
      drive_idle;
      checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL alu_en got %b exp 1", mem_en); end
      checks++; if (wb_alu !== a) begin errors++; $display("FAIL alu_result got %h exp %h", wb_alu, a); end
      checks++; if (wb_rd !== rd) begin errors++; $display("FAIL alu_rd got %0d exp %0d", wb_rd, rd); end
      checks++; if (wb_rw !== rw) begin errors++; $display("FAIL alu_regwrite got %b exp %b", wb_rw, rw); end
      checks++; if (wb_rdata !== 32'h0 || wb_m2r !== 1'b0) begin errors++; $display("FAIL alu_rdata got %h/%b exp 0/0", wb_rdata, wb_m2r); end
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL alu_req got %b exp 0", bus.dmem_req); end
    end else if (mis) begin
      drive_idle;
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL mis_req got %b exp 0", bus.dmem_req); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err got %b exp 1", err); end
      checks++; if (mem_en !== 1'b0 || wb_rw !== 1'b0) begin errors++; $display("FAIL mis_wb got en=%b rw=%b exp 0/0", mem_en, wb_rw); end
      step;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_err_pulse got %b exp 0", err); end
    end else begin
      // Upstream is held during ACCESS; scramble it to show it is ignored.
      ex_valid = 1'($urandom); ex_alu = $urandom; ex_wd = $urandom; ex_rd = 5'($urandom);
      ex_rw = 1'($urandom); ex_mr = 1'($urandom); ex_mw = 1'($urandom); ex_f3 = 3'($urandom);
      obs_we = bus.dmem_we; obs_addr = bus.dmem_addr; obs_be = bus.dmem_be; obs_wdata = bus.dmem_wdata;
      checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL acc_req got %b exp 1", bus.dmem_req); end
      checks++; if (bus.dmem_we !== mw) begin errors++; $display("FAIL acc_we got %b exp %b", bus.dmem_we, mw); end
      checks++; if (bus.dmem_addr !== (a & ~32'h3)) begin errors++; $display("FAIL acc_addr got %h exp %h", bus.dmem_addr, a & ~32'h3); end
      checks++; if (bus.dmem_be !== exp_be) begin errors++; $display("FAIL acc_be got %b exp %b", bus.dmem_be, exp_be); end
      if (mw) begin
        checks++; if (bus.dmem_wdata !== exp_wdata) begin errors++; $display("FAIL acc_wdata got %h exp %h", bus.dmem_wdata, exp_wdata); end
      end
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL acc_en got %b exp 0", mem_en); end
      for (int unsigned i = 0; i < d; i++) begin
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL wait_stall got %b exp 1", stall); end
        checks++; if (bus.dmem_req !== 1'b1 || bus.dmem_addr !== (a & ~32'h3) || bus.dmem_be !== exp_be)
          begin errors++; $display("FAIL wait_hold got req=%b addr=%h be=%b exp 1/%h/%b", bus.dmem_req, bus.dmem_addr, bus.dmem_be, a & ~32'h3, exp_be); end
        if (stall === 1'b1) obs_stall++;
        step;
      end
      bus.dmem_rdata = rdw; bus.dmem_ready = 1'b1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ready_stall got %b exp 1", stall); end
      if (stall === 1'b1) obs_stall++;
      step;
      bus.dmem_ready = 1'b0; bus.dmem_rdata = $urandom;
      drive_idle;
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL done_req got %b exp 0", bus.dmem_req); end
      checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL done_en got %b exp 1", mem_en); end
      checks++; if (wb_rdata !== exp_rdata) begin errors++; $display("FAIL done_rdata got %h exp %h", wb_rdata, exp_rdata); end
      checks++; if (wb_rw !== (rw & load)) begin errors++; $display("FAIL done_regwrite got %b exp %b", wb_rw, rw & load); end
      checks++; if (wb_m2r !== load) begin errors++; $display("FAIL done_memtoreg got %b exp %b", wb_m2r, load); end
      checks++; if (wb_alu !== a || wb_rd !== rd) begin errors++; $display("FAIL done_alu_rd got %h/%0d exp %h/%0d", wb_alu, wb_rd, a, rd); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL done_err got %b exp 0", err); end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b1;
    drive_idle;
    bus.dmem_ready = 1'b0; bus.dmem_rdata = '0;
    #2;
    checks++; if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0) begin errors++; $display("FAIL rst_req_we got %b/%b exp 0/0", bus.dmem_req, bus.dmem_we); end
    checks++; if (bus.dmem_addr !== 32'h0 || bus.dmem_wdata !== 32'h0 || bus.dmem_be !== 4'h0)
      begin errors++; $display("FAIL rst_bus got %h/%h/%b exp 0/0/0", bus.dmem_addr, bus.dmem_wdata, bus.dmem_be); end
    checks++; if (wb_rdata !== 32'h0 || wb_alu !== 32'h0 || wb_rd !== 5'd0 || wb_rw !== 1'b0 || wb_m2r !== 1'b0)
      begin errors++; $display("FAIL rst_wb got %h/%h/%0d/%b/%b exp zeros", wb_rdata, wb_alu, wb_rd, wb_rw, wb_m2r); end
    checks++; if (mem_en !== 1'b0 || err !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_ctl got %b/%b/%b exp 0/0/0", mem_en, err, stall); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_alu_pass;
    do_txn(1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 3'd2, 0, 32'h0);
    checks++; if (wb_alu !== 32'h0000_1234 || wb_rd !== 5'd5 || mem_en !== 1'b1)
      begin errors++; $display("FAIL alu_pass got %h/%0d/%b exp 00001234/5/1", wb_alu, wb_rd, mem_en); end
    checks++; if (obs_stall != 0) begin errors++; $display("FAIL alu_pass_stall got %0d exp 0", obs_stall); end
  endtask

  task automatic test_load_lb;
    do_txn(1'b1, 1'b0, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 3'd0, 2, 32'h80FF_0000);
    checks++; if (obs_addr !== 32'h0000_0100 || obs_be !== 4'b1111) begin errors++; $display("FAIL lb_bus got %h/%b exp 00000100/1111", obs_addr, obs_be); end
    checks++; if (wb_rdata !== 32'hFFFF_FF80 || wb_m2r !== 1'b1) begin errors++; $display("FAIL lb_data got %h/%b exp ffffff80/1", wb_rdata, wb_m2r); end
    checks++; if (obs_stall != 4) begin errors++; $display("FAIL lb_stall_cycles got %0d exp 4", obs_stall); end
  endtask

  task automatic test_store_sh;
    do_txn(1'b0, 1'b1, 32'h0000_0202, 32'h0000_ABCD, 5'd3, 1'b1, 3'd1, 0, 32'h1234_5678);
    checks++; if (obs_we !== 1'b1 || obs_be !== 4'b1100) begin errors++; $display("FAIL sh_bus got we=%b be=%b exp 1/1100", obs_we, obs_be); end
    checks++; if (obs_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata got %h exp abcdabcd", obs_wdata); end
    checks++; if (wb_rw !== 1'b0) begin errors++; $display("FAIL sh_regwrite got %b exp 0", wb_rw); end
  endtask

  task automatic test_timeout;
    int n;
    ex_valid = 1'b1; ex_alu = 32'h40; ex_rd = 5'd9; ex_rw = 1'b1; ex_mr = 1'b1; ex_mw = 1'b0; ex_f3 = 3'd2;
    step;
    drive_idle;
    checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL to_req got %b exp 1", bus.dmem_req); end
    n = 0;
    while (bus.dmem_req === 1'b1 && n < 40) begin
      step;
      n++;
    end
    checks++; if (n != 15) begin errors++; $display("FAIL to_cycles got %0d exp 15", n); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", err); end
    checks++; if (wb_rw !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL to_wb got rw=%b en=%b exp 0/0", wb_rw, mem_en); end
    step;
    checks++; if (err !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL to_pulse got err=%b stall=%b exp 0/0", err, stall); end
  endtask

  task automatic test_reset_mid_access;
    ex_valid = 1'b1; ex_alu = 32'h80; ex_rd = 5'd4; ex_rw = 1'b1; ex_mr = 1'b1; ex_mw = 1'b0; ex_f3 = 3'd2;
    step;
    drive_idle;
    step;
    reset = 1'b1;
    #1;
    checks++; if (bus.dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL mid_rst got req=%b stall=%b exp 0/0", bus.dmem_req, stall); end
    checks++; if (bus.dmem_addr !== 32'h0 || bus.dmem_be !== 4'h0 || mem_en !== 1'b0 || wb_alu !== 32'h0)
      begin errors++; $display("FAIL mid_rst_state got %h/%b/%b/%h exp 0", bus.dmem_addr, bus.dmem_be, mem_en, wb_alu); end
    #1 reset = 1'b0;
    bus.dmem_ready = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
    step;
    step;
    bus.dmem_ready = 1'b0;
    checks++; if (bus.dmem_req !== 1'b0 || mem_en !== 1'b0 || wb_rdata !== 32'h0 || wb_rw !== 1'b0)
      begin errors++; $display("FAIL mid_rst_ready got %b/%b/%h/%b exp 0/0/0/0", bus.dmem_req, mem_en, wb_rdata, wb_rw); end
  endtask

  task automatic test_misalign;
`ifdef MEM_MISALIGN_CHECK_EN
    ex_valid = 1'b1; ex_alu = 32'h41; ex_rd = 5'd2; ex_rw = 1'b1; ex_mr = 1'b1; ex_mw = 1'b0; ex_f3 = 3'd2;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw41_stall got %b exp 0", stall); end
    step;
    drive_idle;
    checks++; if (bus.dmem_req !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL lw41_err got req=%b err=%b exp 0/1", bus.dmem_req, err); end
    step;
    checks++; if (err !== 1'b0 || bus.dmem_req !== 1'b0) begin errors++; $display("FAIL lw41_pulse got err=%b req=%b exp 0/0", err, bus.dmem_req); end
`else
    do_txn(1'b1, 1'b0, 32'h0000_0041, 32'h0, 5'd2, 1'b1, 3'd2, 1, 32'h1122_3344);
    checks++; if (obs_addr !== 32'h0000_0040) begin errors++; $display("FAIL lw41_addr got %h exp 00000040", obs_addr); end
    checks++; if (wb_rdata !== 32'h1122_3344) begin errors++; $display("FAIL lw41_data got %h exp 11223344", wb_rdata); end
`endif
  endtask

  task automatic test_bubble;
    do_txn(1'b0, 1'b0, 32'hCAFE_0000, 32'h0, 5'd11, 1'b1, 3'd0, 0, 32'h0);
    bus.dmem_ready = 1'b1;
    step;
    bus.dmem_ready = 1'b0;
    checks++; if (mem_en !== 1'b0 || wb_rw !== 1'b0) begin errors++; $display("FAIL bubble_ctl got en=%b rw=%b exp 0/0", mem_en, wb_rw); end
    checks++; if (wb_alu !== 32'hCAFE_0000 || wb_rd !== 5'd11) begin errors++; $display("FAIL bubble_hold got %h/%0d exp cafe0000/11", wb_alu, wb_rd); end
    checks++; if (bus.dmem_req !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL bubble_bus got req=%b err=%b exp 0/0", bus.dmem_req, err); end
  endtask

  task automatic test_random;
    logic [2:0] f3;
    int unsigned kind;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      if (kind == 1) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 2));
      end
      do_txn(kind == 1, kind == 2, $urandom, $urandom, 5'($urandom), 1'($urandom), f3,
             $urandom_range(0, WAIT_LIMIT - 1), $urandom);
      repeat ($urandom_range(0, 2)) begin
        step;
        checks++; if (mem_en !== 1'b0 || wb_rw !== 1'b0) begin errors++; $display("FAIL rnd_bubble got en=%b rw=%b exp 0/0", mem_en, wb_rw); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_alu_pass;
    test_load_lb;
    test_store_sh;
    test_timeout;
    test_reset_mid_access;
    test_misalign;
    test_bubble;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
